controle_cruzamento: RTL and testbench

CONTROLE_CRUZAMENTO -- requirements
Module: controle_cruzamento

---
 rtl/controle_cruzamento.sv | 177 +++++++++++++++++
 tb/tb_controle_cruzamento.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/controle_cruzamento.sv
// Crossing controller: main road, side road and pedestrian phase with fair arbitration.
// Night blink mode is built only when CONTROLE_NOTURNO_EN is defined.
module controle_cruzamento #(
    parameter int unsigned T_MIN_VERDE = 8,
    parameter int unsigned T_VERDE     = 6,
    parameter int unsigned T_AMARELO   = 2,
    parameter int unsigned T_PEDESTRE  = 4,
    parameter int unsigned T_LIMPEZA   = 1,
    parameter int unsigned T_PISCA     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_sec,
    input  logic       botao_pedestre,
    input  logic       modo_noturno,
    output logic       vp_verm,
    output logic       vp_amar,
    output logic       vp_verde,
    output logic       vs_verm,
    output logic       vs_amar,
    output logic       vs_verde,
    output logic       ped_verm,
    output logic       ped_verde,
    output logic       ped_ack,
    output logic [2:0] estado
);

    localparam logic [2:0] StPrincVerde = 3'd0;
    localparam logic [2:0] StPrincAmar  = 3'd1;
    localparam logic [2:0] StSecVerde   = 3'd2;
    localparam logic [2:0] StSecAmar    = 3'd3;
    localparam logic [2:0] StPedVerde   = 3'd4;
    localparam logic [2:0] StTudoVerm   = 3'd5;
    localparam logic [2:0] StNoturno    = 3'd6;

    localparam logic [7:0] FimMinVerde = 8'(T_MIN_VERDE - 1);
    localparam logic [7:0] FimVerde    = 8'(T_VERDE - 1);
    localparam logic [7:0] FimAmarelo  = 8'(T_AMARELO - 1);
    localparam logic [7:0] FimPedestre = 8'(T_PEDESTRE - 1);
    localparam logic [7:0] FimLimpeza  = 8'(T_LIMPEZA - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       ped_pend_q, ped_pend_d;
    logic       sec_pend_q, sec_pend_d;
    logic       ultimo_q, ultimo_d;
    logic       entra;
    logic       noturno_req;

`ifdef CONTROLE_NOTURNO_EN
    localparam logic [7:0] FimPisca = 8'(T_PISCA - 1);

    logic [7:0] pisca_cnt_q;
    logic       pisca_fase_q;
    logic       ambar_pisca;

    // Phase 0 means amber on; counter and phase rest at zero outside night mode.
    always_ff @(posedge clk) begin
        if (rst || state_q != StNoturno) begin
            pisca_cnt_q  <= 8'd0;
            pisca_fase_q <= 1'b0;
        end else if (pisca_cnt_q == FimPisca) begin
            pisca_cnt_q  <= 8'd0;
            pisca_fase_q <= ~pisca_fase_q;
        end else begin
            pisca_cnt_q  <= pisca_cnt_q + 8'd1;
        end
    end

    assign noturno_req = modo_noturno;
    assign ambar_pisca = ~pisca_fase_q;
`else
    logic unused_noturno;

    assign noturno_req    = 1'b0;
    assign unused_noturno = modo_noturno | (T_PISCA == 0);
`endif

    always_comb begin
        state_d  = state_q;
        ultimo_d = ultimo_q;
        case (state_q)
            StPrincVerde: begin
                if (noturno_req) begin
                    state_d = StNoturno;
                end else if (timer_q >= FimMinVerde && (ped_pend_q || sec_pend_q)) begin
                    state_d = StPrincAmar;
                end
            end
            StPrincAmar: begin
                if (timer_q == FimAmarelo) begin
                    // ultimo = 1: side road served last, so the pedestrian wins a tie
                    if (ped_pend_q && (!sec_pend_q || ultimo_q)) begin
                        state_d  = StPedVerde;
                        ultimo_d = 1'b0;
                    end else if (sec_pend_q) begin
                        state_d  = StSecVerde;
                        ultimo_d = 1'b1;
                    end else begin
                        state_d  = StPrincVerde;
                    end
                end
            end
            StSecVerde: if (timer_q == FimVerde)    state_d = StSecAmar;
            StSecAmar:  if (timer_q == FimAmarelo)  state_d = StTudoVerm;
            StPedVerde: if (timer_q == FimPedestre) state_d = StTudoVerm;
            StTudoVerm: if (timer_q == FimLimpeza)  state_d = StPrincVerde;
`ifdef CONTROLE_NOTURNO_EN
            StNoturno:  if (!modo_noturno)          state_d = StTudoVerm;
`endif
            default:    state_d = StTudoVerm;
        endcase
    end

    always_comb begin
        entra      = (state_d != state_q);
        ped_pend_d = ped_pend_q |
                     (botao_pedestre && state_q != StPedVerde && state_q != StNoturno);
        sec_pend_d = sec_pend_q |
                     (sensor_sec && state_q != StSecVerde && state_q != StNoturno);
        if (entra && state_d == StPedVerde) ped_pend_d = 1'b0;
        if (entra && state_d == StSecVerde) sec_pend_d = 1'b0;
        if (entra && state_d == StNoturno) begin
            ped_pend_d = 1'b0;
            sec_pend_d = 1'b0;
        end
        if (entra) begin
            timer_d = 8'd0;
        end else if (timer_q == 8'hFF) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StPrincVerde;
            timer_q    <= 8'd0;
            ped_pend_q <= 1'b0;
            sec_pend_q <= 1'b0;
            ultimo_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            sec_pend_q <= sec_pend_d;
            ultimo_q   <= ultimo_d;
        end
    end

    always_comb begin
        vp_verm   = 1'b0;
        vp_amar   = 1'b0;
        vp_verde  = 1'b0;
        vs_verm   = 1'b0;
        vs_amar   = 1'b0;
        vs_verde  = 1'b0;
        ped_verm  = 1'b0;
        ped_verde = 1'b0;
        case (state_q)
            StPrincVerde: begin vp_verde = 1'b1; vs_verm  = 1'b1; ped_verm  = 1'b1; end
            StPrincAmar:  begin vp_amar  = 1'b1; vs_verm  = 1'b1; ped_verm  = 1'b1; end
            StSecVerde:   begin vp_verm  = 1'b1; vs_verde = 1'b1; ped_verm  = 1'b1; end
            StSecAmar:    begin vp_verm  = 1'b1; vs_amar  = 1'b1; ped_verm  = 1'b1; end
            StPedVerde:   begin vp_verm  = 1'b1; vs_verm  = 1'b1; ped_verde = 1'b1; end
`ifdef CONTROLE_NOTURNO_EN
            StNoturno:    begin vp_amar  = ambar_pisca; vs_amar = ambar_pisca; end
`endif
            default:      begin vp_verm  = 1'b1; vs_verm  = 1'b1; ped_verm  = 1'b1; end
        endcase
    end

    assign ped_ack = ped_pend_q;
    assign estado  = state_q;

endmodule

// File: tb/tb_controle_cruzamento.sv
// Scoreboard bench for controle_cruzamento: expected lamp/ack/state per cycle come from
// scenario timelines; night scenario runs only when CONTROLE_NOTURNO_EN is defined.
module tb_controle_cruzamento;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_sec;
    logic       botao_pedestre;
    logic       modo_noturno;
    logic       vp_verm, vp_amar, vp_verde;
    logic       vs_verm, vs_amar, vs_verde;
    logic       ped_verm, ped_verde, ped_ack;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb_q[$];

`ifdef CONTROLE_NOTURNO_EN
    localparam bit ModoA = 1'b0;
    localparam int NScn  = 7;
`else
    // Night request must be ignored in this build
    localparam bit ModoA = 1'b1;
    localparam int NScn  = 6;
`endif

    controle_cruzamento dut (
        .clk           (clk),
        .rst           (rst),
        .sensor_sec    (sensor_sec),
        .botao_pedestre(botao_pedestre),
        .modo_noturno  (modo_noturno),
        .vp_verm       (vp_verm),
        .vp_amar       (vp_amar),
        .vp_verde      (vp_verde),
        .vs_verm       (vs_verm),
        .vs_amar       (vs_amar),
        .vs_verde      (vs_verde),
        .ped_verm      (ped_verm),
        .ped_verde     (ped_verde),
        .ped_ack       (ped_ack),
        .estado        (estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (lamps vp3 vs3 ped2, ack, estado)", tag, got, exp);
        end
    endtask

    // {vp_verm,vp_amar,vp_verde, vs_verm,vs_amar,vs_verde, ped_verm,ped_verde, ack, estado}
    function automatic logic [11:0] pack(input logic [2:0] st, input logic ack, input logic amb);
        logic [7:0] l;
        case (st)
            3'd0:    l = 8'b001_100_10;
            3'd1:    l = 8'b010_100_10;
            3'd2:    l = 8'b100_001_10;
            3'd3:    l = 8'b100_010_10;
            3'd4:    l = 8'b100_100_01;
            3'd6:    l = amb ? 8'b010_010_00 : 8'b000_000_00;
            default: l = 8'b100_100_10;
        endcase
        return {l, ack, st};
    endfunction

    function automatic int ncyc(input int id);
        case (id)
            0: return 22;
            1: return 52;
            2: return 32;
            3: return 40;
            4: return 310;
            5: return 275;
            default: return 20;
        endcase
    endfunction

    // {rst, botao, sensor, modo}
    function automatic logic [3:0] stim(input int id, input int c);
        logic r, b, s, m;
        r = 1'b0; b = 1'b0; s = 1'b0; m = 1'b0;
        case (id)
            0: begin b = (c == 3); m = ModoA; end
            1: begin b = (c == 2 || c == 16); s = (c == 2); end
            2: b = (c == 3 || (c >= 10 && c <= 13));
            3: begin s = (c == 2 || c == 11); b = (c == 11); r = (c == 12); end
            4: b = (c == 300);
            5: b = (c == 258);
            default: begin b = (c == 0); m = (c >= 1 && c <= 9); end
        endcase
        return {r, b, s, m};
    endfunction

    // {estado, ack, amber-on}
    function automatic logic [4:0] expect_of(input int id, input int c);
        logic [2:0] st;
        logic       ack, amb;
        st = 3'd0; ack = 1'b0; amb = 1'b0;
        case (id)
            0, 2: begin
                if (c >= 8 && c <= 9)        st = 3'd1;
                else if (c >= 10 && c <= 13) st = 3'd4;
                else if (c == 14)            st = 3'd5;
                ack = (c >= 4 && c <= 9);
            end
            1: begin
                if (c >= 8 && c <= 9)        st = 3'd1;
                else if (c >= 10 && c <= 13) st = 3'd4;
                else if (c == 14)            st = 3'd5;
                else if (c >= 23 && c <= 24) st = 3'd1;
                else if (c >= 25 && c <= 30) st = 3'd2;
                else if (c >= 31 && c <= 32) st = 3'd3;
                else if (c == 33)            st = 3'd5;
                else if (c >= 42 && c <= 43) st = 3'd1;
                else if (c >= 44 && c <= 47) st = 3'd4;
                else if (c == 48)            st = 3'd5;
                ack = (c >= 3 && c <= 9) || (c >= 17 && c <= 43);
            end
            3: begin
                if (c >= 8 && c <= 9)        st = 3'd1;
                else if (c >= 10 && c <= 12) st = 3'd2;
                ack = (c == 12);
            end
            4: begin
                if (c >= 302 && c <= 303)      st = 3'd1;
                else if (c >= 304 && c <= 307) st = 3'd4;
                else if (c == 308)             st = 3'd5;
                ack = (c >= 301 && c <= 303);
            end
            5: begin
                if (c >= 260 && c <= 261)      st = 3'd1;
                else if (c >= 262 && c <= 265) st = 3'd4;
                else if (c == 266)             st = 3'd5;
                ack = (c >= 259 && c <= 261);
            end
            default: begin
                if (c >= 2 && c <= 10) begin
                    st  = 3'd6;
                    amb = (((c - 2) / 2) % 2 == 0);
                end else if (c == 11) begin
                    st = 3'd5;
                end
                ack = (c == 1);
            end
        endcase
        return {st, ack, amb};
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        botao_pedestre = 1'b0;
        sensor_sec     = 1'b0;
        modo_noturno   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_scn(input int id);
        logic [3:0]  s;
        logic [4:0]  e;
        logic [11:0] got;
        do_reset();
        for (int c = 0; c < ncyc(id); c++) begin
            s = stim(id, c);
            rst            = s[3];
            botao_pedestre = s[2];
            sensor_sec     = s[1];
            modo_noturno   = s[0];
            e = expect_of(id, c);
            sb_q.push_back(pack(e[4:2], e[1], e[0]));
            @(negedge clk);
            got = {vp_verm, vp_amar, vp_verde, vs_verm, vs_amar, vs_verde,
                   ped_verm, ped_verde, ped_ack, estado};
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL s%0d c%0d: scoreboard empty", id, c);
            end else begin
                check($sformatf("s%0d c%0d", id, c), got, sb_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int id = 0; id < NScn; id++) run_scn(id);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
